stutter_timer: RTL

//  Parametrised, run-time programmable tick generator. Counts 0..period and pulses cy on the

---
 rtl/stutter_timer.sv | 114 +++++++++++
 1 files changed

// File: rtl/stutter_timer.sv
// stutter_timer: run-time programmable tick generator.
// Counts 0..period and asserts cy on the terminal count. In periodic mode the
// count then wraps to 0; in one-shot mode the timer stops in DONE. The period
// and mode are captured on load. The stop strobe returns the timer to IDLE.
// en stalls counting while the timer is running.
module stutter_timer #(
    parameter int          WIDTH        = 16,
    parameter int unsigned RESET_PERIOD = 2**16 - 1,
    parameter bit          AUTOSTART    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active low
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic             oneshot,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             cy,
    output logic             busy,
    output logic             done
);

    // State encoding: bit 0 is busy and bit 1 is done. Both flags therefore
    // come straight from flops with no decode logic.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] RESET_PERIOD_W = RESET_PERIOD[WIDTH-1:0];
    localparam state_t           RESET_STATE    = AUTOSTART ? ST_RUN : ST_IDLE;

    state_t           state_reg,   state_next;
    logic [WIDTH-1:0] cnt_reg,     cnt_next;
    logic [WIDTH-1:0] period_reg,  period_next;
    logic             oneshot_reg, oneshot_next;

    logic             at_terminal;
    logic             running;

    // The terminal compare happens before the increment. An all-ones period
    // therefore gives a full 2**WIDTH cycle without overflow.
    assign at_terminal = (cnt_reg == period_reg);
    assign running     = (state_reg == ST_RUN);

    // State and datapath registers. The reset is async assert; release is
    // sampled on clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= RESET_STATE;
            cnt_reg     <= '0;
            period_reg  <= RESET_PERIOD_W;
            oneshot_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            period_reg  <= period_next;
            oneshot_reg <= oneshot_next;
        end
    end

    // Next-state logic. Priority is: load, then stop, then normal counting.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        period_next  = period_reg;
        oneshot_next = oneshot_reg;

        if (load) begin
            // Load can happen from any state. The new period starts at 0
            // on the next cycle.
            period_next  = period;
            oneshot_next = oneshot;
            cnt_next     = '0;
            state_next   = ST_RUN;
        end else if (stop) begin
            cnt_next   = '0;
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_RUN: begin
                    if (en) begin
                        if (at_terminal) begin
                            cnt_next = '0;
                            if (oneshot_reg) begin
                                state_next = ST_DONE;
                            end
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    cnt_next = '0;
                end
                default: begin
                    // The unused encoding recovers to IDLE.
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // cy is the only combinational output. It can still fire in a load or
    // stop cycle when the old terminal count is reached.
    assign cy    = running & en & at_terminal;
    assign count = cnt_reg;
    assign busy  = state_reg[0];
    assign done  = state_reg[1];

endmodule
